// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state encoding and PC constants for the fetch stage.
package pc_pkg;
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with enable that sticks at all-ones; ports clk_i, rst_i (async high), en_i, count_o.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) count_q <= '0;
    else if (en_i && ~&count_q) count_q <= count_q + W'(1);
  assign count_o = count_q;
endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: PC register with boot bubble, stall hold, redirect flush, sticky misalign flag and optional PC_PERF_COUNT_EN counters; ports Clk, Reset, Stall, Redirect, NextPC -> PCResult, PCPlus4, FetchValid, MisalignErr, InstrCount, StallCount.
module pc_fetch_stage
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_W      = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [31:0]        NextPC,
  output logic [31:0]        PCResult,
  output logic [31:0]        PCPlus4,
  output logic               FetchValid,
  output logic               MisalignErr,
  output logic [COUNT_W-1:0] InstrCount,
  output logic [COUNT_W-1:0] StallCount
);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        load;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  // RUN, HOLD and FLUSH share transitions; they differ only in FetchValid.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    load    = (state_q != S_BOOT) && (Redirect || !Stall);
    state_d = (state_q == S_BOOT) ? S_RUN :
              Redirect            ? S_FLUSH :
              Stall               ? S_HOLD : S_RUN;
    pc_d    = load ? (NextPC & PC_ALIGN_MASK) : pc_q;
    err_d   = err_q | (load && |NextPC[1:0]);
  end
  assign PCResult    = pc_q;
  assign PCPlus4     = pc_q + PC_INC;
  assign FetchValid  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign MisalignErr = err_q;
`ifdef PC_PERF_COUNT_EN
  logic instr_en, stall_en;
  assign instr_en = FetchValid && !Stall;
  assign stall_en = Stall && (state_q != S_BOOT);
  sat_counter #(.W(COUNT_W)) u_instr_cnt (
    .clk_i(Clk), .rst_i(Reset), .en_i(instr_en), .count_o(InstrCount)
  );
  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk_i(Clk), .rst_i(Reset), .en_i(stall_en), .count_o(StallCount)
  );
`else
  assign InstrCount = '0;
  assign StallCount = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: scoreboard bench for pc_fetch_stage against a bubble/flag reference model.
module tb_pc_fetch_stage;
  localparam logic [31:0] RV = 32'h0000_0100;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PC_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic          Clk = 1'b0, Reset = 1'b1, Stall = 1'b0, Redirect = 1'b0;
  logic [31:0]   NextPC = '0;
  logic [31:0]   PCResult, PCPlus4;
  logic          FetchValid, MisalignErr;
  logic [CW-1:0] InstrCount, StallCount;
  pc_fetch_stage #(.RESET_VECTOR(RV), .COUNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .NextPC(NextPC),
    .PCResult(PCResult), .PCPlus4(PCPlus4), .FetchValid(FetchValid),
    .MisalignErr(MisalignErr), .InstrCount(InstrCount), .StallCount(StallCount)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        err;
    int          ic;
    int          sc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passes = 0;
  logic [31:0] m_pc;
  bit m_boot, m_flush, m_err;
  int m_ic, m_sc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic reset_model();
    m_pc = RV; m_boot = 1; m_flush = 0; m_err = 0; m_ic = 0; m_sc = 0;
  endtask
  function automatic int sat(input int v);
    return v < CMAX ? v + 1 : v;
  endfunction
  // Drive one cycle's inputs (at a falling edge), predict the post-edge outputs.
  // The model is just "one bubble after boot, one bubble after each redirect";
  // any non-held cycle takes NextPC with the low two bits dropped.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] np);
    Stall = st; Redirect = rd; NextPC = np;
    if (m_boot) m_boot = 0;
    else begin
      if (!m_flush && !st) m_ic = sat(m_ic);
      if (st) m_sc = sat(m_sc);
      if (rd || !st) begin
        m_pc  = np & ~32'h3;
        m_err = m_err | (np[1:0] != 2'b00);
      end
      m_flush = rd;
    end
    q.push_back('{m_pc, !m_flush, m_err, m_ic, m_sc});
    @(negedge Clk);
  endtask
  always @(posedge Clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc", PCResult, e.pc);
      chk("pcplus4", PCPlus4, e.pc + 32'd4);
      chk("valid", {31'b0, FetchValid}, {31'b0, e.valid});
      chk("misalign", {31'b0, MisalignErr}, {31'b0, e.err});
      chk("instr_cnt", 32'(InstrCount), PERF ? 32'(e.ic) : 32'd0);
      chk("stall_cnt", 32'(StallCount), PERF ? 32'(e.sc) : 32'd0);
    end
  end
  initial begin
    reset_model();
    repeat (2) @(negedge Clk);
    chk("rst_pc", PCResult, RV);
    chk("rst_pcplus4", PCPlus4, RV + 32'd4);
    chk("rst_valid", {31'b0, FetchValid}, 32'd0);
    chk("rst_err", {31'b0, MisalignErr}, 32'd0);
    chk("rst_icnt", 32'(InstrCount), 32'd0);
    chk("rst_scnt", 32'(StallCount), 32'd0);
    Reset = 1'b0;
    #1 chk("boot_valid", {31'b0, FetchValid}, 32'd0);
    chk("boot_pc", PCResult, RV);
    cycle(1, 1, 32'h0000_0777);
    for (int i = 0; i < 4; i++) cycle(0, 0, m_pc + 32'd4);
    for (int i = 0; i < 3; i++) cycle(1, 0, m_pc + 32'd4);
    cycle(0, 0, m_pc + 32'd4);
    cycle(1, 1, 32'h0000_0400);
    cycle(0, 0, m_pc + 32'd4);
    cycle(0, 0, m_pc + 32'd4);
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, m_pc + 32'd4);
    cycle(0, 0, m_pc + 32'd4);
    cycle(0, 1, 32'h0000_0203);
    for (int i = 0; i < 3; i++) cycle(0, 0, m_pc + 32'd4);
    for (int i = 0; i < 800; i++) begin
      bit st, rd;
      st = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 7) == 0);
      cycle(st, rd, rd ? $urandom() : m_pc + 32'd4);
    end
    cycle(0, 1, 32'h0000_0800);
    #2 Reset = 1'b1;
    #1 chk("async_rst_pc", PCResult, RV);
    chk("async_rst_valid", {31'b0, FetchValid}, 32'd0);
    chk("async_rst_err", {31'b0, MisalignErr}, 32'd0);
    chk("async_rst_icnt", 32'(InstrCount), 32'd0);
    chk("async_rst_scnt", 32'(StallCount), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    reset_model();
    cycle(0, 0, m_pc + 32'd4);
    for (int i = 0; i < 5; i++) cycle(0, 0, m_pc + 32'd4);
    @(negedge Clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
